// File: rtl/ptp_pkg.sv
// Shared definitions for the PTP transmit scheduler: message codes, FSM
// state encoding and a constant-friendly clog2.
package ptp_pkg;

  typedef enum logic [2:0] {
    MSG_ANNOUNCE       = 3'd0,
    MSG_SYNC           = 3'd1,
    MSG_FOLLOW_UP      = 3'd2,
    MSG_PDELAY_REQ     = 3'd3,
    MSG_PDELAY_RESP    = 3'd4,
    MSG_PDELAY_RESP_FU = 3'd5
  } msg_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int REQ_NUM = 6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ptp_lsb_index.sv
// Combinational lowest-set-bit encoder with a nonzero flag; the index is 0
// when the vector is empty.
module ptp_lsb_index #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             nz_o
);

  always_comb begin
    idx_o = '0;
    nz_o  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        nz_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptp_tx_msg_sched.sv
// Serialises the six PTP message requests into single-port transmit
// commands, with a per-command watchdog and a one-cycle ack per request.
module ptp_tx_msg_sched
  import ptp_pkg::*;
#(
  parameter int PORT_NUM       = 8,
  parameter int PORT_NUM_WIDTH = clog2(PORT_NUM),
  parameter int TIMEOUT_CYC    = 1024,
  parameter int TO_WIDTH       = clog2(TIMEOUT_CYC + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_announce_req,
  input  logic                      i_sync_req,
  input  logic                      i_follow_up_req,
  input  logic                      i_pdelayreq_req,
  input  logic                      i_pdelayresp_req,
  input  logic                      i_pdelayresp_fw_req,
  input  logic [PORT_NUM-1:0]       i_announce_port,
  input  logic [PORT_NUM-1:0]       i_sync_port,
  input  logic [PORT_NUM-1:0]       i_follow_up_port,
  input  logic [PORT_NUM-1:0]       i_pdelay_req_port,
  input  logic [PORT_NUM-1:0]       i_pdelay_resp_port,
  input  logic [PORT_NUM-1:0]       i_pdelay_resp_fu_port,
  output logic                      o_announce_ack,
  output logic                      o_sync_ack,
  output logic                      o_follow_up_ack,
  output logic                      o_pdelayreq_ack,
  output logic                      o_pdelayresp_ack,
  output logic                      o_pdelayresp_fw_ack,
  output logic                      o_tx_valid,
  output logic [2:0]                o_tx_msg_type,
  output logic [PORT_NUM_WIDTH-1:0] o_tx_port,
  input  logic                      i_tx_ready,
  output logic                      o_drop_pulse,
  output logic [15:0]               o_drop_cnt
);

  state_e                state_q, state_d;
  msg_type_e             type_q, type_d, win_type;
  logic [PORT_NUM-1:0]   vec_q, vec_d, win_vec;
  logic [TO_WIDTH-1:0]   wdog_q, wdog_d;
  logic                  drop_pulse_q, drop_pulse_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic [REQ_NUM-1:0]    req_prio;
  logic [2:0]            req_idx;
  logic                  req_nz;
  logic [PORT_NUM_WIDTH-1:0] port_idx;
  logic                  port_nz;
  logic                  hs, timeout;

  // Bit 0 is the highest priority: lowest-set-bit search doubles as arbiter.
  assign req_prio = {i_announce_req, i_pdelayreq_req, i_follow_up_req,
                     i_sync_req, i_pdelayresp_fw_req, i_pdelayresp_req};

  ptp_lsb_index #(.W(REQ_NUM), .IDX_W(3)) u_arb (
    .vec_i (req_prio),
    .idx_o (req_idx),
    .nz_o  (req_nz)
  );

  ptp_lsb_index #(.W(PORT_NUM), .IDX_W(PORT_NUM_WIDTH)) u_port (
    .vec_i (vec_q),
    .idx_o (port_idx),
    .nz_o  (port_nz)
  );

  always_comb begin
    case (req_idx)
      3'd0:    begin win_type = MSG_PDELAY_RESP;    win_vec = i_pdelay_resp_port;    end
      3'd1:    begin win_type = MSG_PDELAY_RESP_FU; win_vec = i_pdelay_resp_fu_port; end
      3'd2:    begin win_type = MSG_SYNC;           win_vec = i_sync_port;           end
      3'd3:    begin win_type = MSG_FOLLOW_UP;      win_vec = i_follow_up_port;      end
      3'd4:    begin win_type = MSG_PDELAY_REQ;     win_vec = i_pdelay_req_port;     end
      default: begin win_type = MSG_ANNOUNCE;       win_vec = i_announce_port;       end
    endcase
  end

  assign o_tx_valid = (state_q == ST_SEND) && port_nz;
  assign hs         = o_tx_valid && i_tx_ready;
  // A handshake in the expiry cycle wins over the drop.
  assign timeout    = o_tx_valid && !i_tx_ready &&
                      (wdog_q == TO_WIDTH'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    vec_d        = vec_q;
    wdog_d       = wdog_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_nz) begin
          type_d  = win_type;
          vec_d   = win_vec;
          wdog_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs || timeout) begin
          vec_d  = vec_q & (vec_q - PORT_NUM'(1));
          wdog_d = '0;
          if (timeout) begin
            drop_pulse_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else if (o_tx_valid) begin
          wdog_d = wdog_q + TO_WIDTH'(1);
        end
        if (vec_d == '0) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      type_q       <= MSG_ANNOUNCE;
      vec_q        <= '0;
      wdog_q       <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      vec_q        <= vec_d;
      wdog_q       <= wdog_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign o_tx_msg_type       = type_q;
  assign o_tx_port           = port_idx;
  assign o_drop_pulse        = drop_pulse_q;
  assign o_drop_cnt          = drop_cnt_q;
  assign o_announce_ack      = (state_q == ST_ACK) && (type_q == MSG_ANNOUNCE);
  assign o_sync_ack          = (state_q == ST_ACK) && (type_q == MSG_SYNC);
  assign o_follow_up_ack     = (state_q == ST_ACK) && (type_q == MSG_FOLLOW_UP);
  assign o_pdelayreq_ack     = (state_q == ST_ACK) && (type_q == MSG_PDELAY_REQ);
  assign o_pdelayresp_ack    = (state_q == ST_ACK) && (type_q == MSG_PDELAY_RESP);
  assign o_pdelayresp_fw_ack = (state_q == ST_ACK) && (type_q == MSG_PDELAY_RESP_FU);

endmodule

// File: tb/tb_ptp_tx_msg_sched.sv
// Bench for ptp_tx_msg_sched: directed scenarios with literal expectations,
// then randomized traffic checked cycle by cycle against a queue-based model.
module tb_ptp_tx_msg_sched;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req [6];
  logic [7:0] pv [6];
  logic       ack [6];
  logic       ready;
  logic       tx_valid;
  logic [2:0] tx_type;
  logic [2:0] tx_port;
  logic       drop_pulse;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic ack_seen [6];
  bit   rand_on = 1'b0;

  // model state: phase 0 idle, 1 sending, 2 ack, 3 gap
  int   m_ph = 0;
  int   m_type = 0;
  int   m_ports[$];
  int   m_stall = 0;
  bit   m_dp = 1'b0;
  int   m_cnt = 0;
  int   prio [6];

  always #5 clk = ~clk;

  ptp_tx_msg_sched #(.PORT_NUM(8), .TIMEOUT_CYC(TO)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst_n),
    .i_announce_req        (req[0]),
    .i_sync_req            (req[1]),
    .i_follow_up_req       (req[2]),
    .i_pdelayreq_req       (req[3]),
    .i_pdelayresp_req      (req[4]),
    .i_pdelayresp_fw_req   (req[5]),
    .i_announce_port       (pv[0]),
    .i_sync_port           (pv[1]),
    .i_follow_up_port      (pv[2]),
    .i_pdelay_req_port     (pv[3]),
    .i_pdelay_resp_port    (pv[4]),
    .i_pdelay_resp_fu_port (pv[5]),
    .o_announce_ack        (ack[0]),
    .o_sync_ack            (ack[1]),
    .o_follow_up_ack       (ack[2]),
    .o_pdelayreq_ack       (ack[3]),
    .o_pdelayresp_ack      (ack[4]),
    .o_pdelayresp_fw_ack   (ack[5]),
    .o_tx_valid            (tx_valid),
    .o_tx_msg_type         (tx_type),
    .o_tx_port             (tx_port),
    .i_tx_ready            (ready),
    .o_drop_pulse          (drop_pulse),
    .o_drop_cnt            (drop_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: arbitration by priority list, port queue in ascending order.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ph = 0; m_stall = 0; m_dp = 1'b0; m_cnt = 0;
      m_ports.delete();
      for (int t = 0; t < 6; t++) ack_seen[t] = 1'b0;
      chk("rst_valid", 32'(tx_valid), 0);
      chk("rst_port", 32'(tx_port), 0);
      chk("rst_type", 32'(tx_type), 0);
      chk("rst_drop_pulse", 32'(drop_pulse), 0);
      chk("rst_drop_cnt", 32'(drop_cnt), 0);
      for (int t = 0; t < 6; t++) chk("rst_ack", 32'(ack[t]), 0);
    end else begin
      bit ev;
      ev = (m_ph == 1) && (m_ports.size() > 0);
      chk("m_valid", 32'(tx_valid), 32'(ev));
      if (ev) begin
        chk("m_port", 32'(tx_port), 32'(m_ports[0]));
        chk("m_type", 32'(tx_type), 32'(m_type));
      end
      for (int t = 0; t < 6; t++) begin
        chk("m_ack", 32'(ack[t]), 32'((m_ph == 2) && (m_type == t)));
        ack_seen[t] = ack[t];
      end
      chk("m_drop_pulse", 32'(drop_pulse), 32'(m_dp));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(m_cnt));
      m_dp = 1'b0;
      case (m_ph)
        0: begin
          for (int k = 0; k < 6; k++) begin
            if (m_ph == 0 && req[prio[k]]) begin
              m_type = prio[k];
              m_ports.delete();
              for (int b = 0; b < 8; b++) if (pv[m_type][b]) m_ports.push_back(b);
              m_stall = 0;
              m_ph = 1;
            end
          end
        end
        1: begin
          if (ev) begin
            if (ready) begin
              void'(m_ports.pop_front());
              m_stall = 0;
            end else if (m_stall == TO - 1) begin
              void'(m_ports.pop_front());
              m_stall = 0;
              m_dp = 1'b1;
              if (m_cnt < 16'hFFFF) m_cnt++;
            end else begin
              m_stall++;
            end
          end
          if (m_ports.size() == 0) m_ph = 2;
        end
        2: m_ph = 3;
        default: m_ph = 0;
      endcase
    end
  end

  // Requester side: drop a request the cycle after its ack, optionally add traffic.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int t = 0; t < 6; t++) begin
      if (ack_seen[t]) req[t] = 1'b0;
      if (rand_on) begin
        if (!req[t] && !ack_seen[t] && $urandom_range(0, 7) == 0) begin
          req[t] = 1'b1;
          pv[t]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end else if (req[t] && $urandom_range(0, 31) == 0) begin
          pv[t] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int got[$];
    int rmode;
    prio[0] = 4; prio[1] = 5; prio[2] = 1; prio[3] = 2; prio[4] = 3; prio[5] = 0;
    for (int t = 0; t < 6; t++) begin
      req[t] = 1'b0; pv[t] = 8'h00; ack_seen[t] = 1'b0;
    end
    ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single sync, ports 0 and 2 back to back
    tick(); req[1] = 1'b1; pv[1] = 8'h05;
    @(negedge clk); chk("t1_idle_valid", 32'(tx_valid), 0);
    tick(); @(negedge clk);
    chk("t1_v0", 32'(tx_valid), 1); chk("t1_type0", 32'(tx_type), 1); chk("t1_port0", 32'(tx_port), 0);
    tick(); @(negedge clk);
    chk("t1_v1", 32'(tx_valid), 1); chk("t1_port1", 32'(tx_port), 2);
    tick(); @(negedge clk);
    chk("t1_ack", 32'(ack[1]), 1); chk("t1_ack_valid", 32'(tx_valid), 0);
    tick(); @(negedge clk); chk("t1_ack_once", 32'(ack[1]), 0);
    idle(3);

    // Announce vs pdelay_resp in the same cycle
    tick(); req[0] = 1'b1; pv[0] = 8'h01; req[4] = 1'b1; pv[4] = 8'h01;
    tick(); @(negedge clk); chk("t2_first_type", 32'(tx_type), 4); chk("t2_first_v", 32'(tx_valid), 1);
    tick(); @(negedge clk); chk("t2_resp_ack", 32'(ack[4]), 1); chk("t2_ann_ack_early", 32'(ack[0]), 0);
    tick(); @(negedge clk); chk("t2_gap_v", 32'(tx_valid), 0);
    tick(); @(negedge clk); chk("t2_idle_v", 32'(tx_valid), 0);
    tick(); @(negedge clk); chk("t2_second_type", 32'(tx_type), 0); chk("t2_second_v", 32'(tx_valid), 1);
    tick(); @(negedge clk); chk("t2_ann_ack", 32'(ack[0]), 1);
    idle(4);

    // Follow_up with empty vector
    tick(); req[2] = 1'b1; pv[2] = 8'h00;
    tick(); @(negedge clk); chk("t3_no_valid", 32'(tx_valid), 0); chk("t3_ack_early", 32'(ack[2]), 0);
    tick(); @(negedge clk); chk("t3_ack", 32'(ack[2]), 1);
    idle(4);

    // Watchdog drop on port 0, then port 1 accepted
    tick(); req[3] = 1'b1; pv[3] = 8'h03; ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(); @(negedge clk);
      if (i == 16) begin
        chk("t4_stall_v", 32'(tx_valid), 1); chk("t4_stall_port", 32'(tx_port), 0);
        chk("t4_no_drop_yet", 32'(drop_pulse), 0);
      end
    end
    tick(); @(negedge clk);
    chk("t4_drop_pulse", 32'(drop_pulse), 1); chk("t4_drop_cnt", 32'(drop_cnt), 1);
    chk("t4_next_port", 32'(tx_port), 1);
    tick(); ready = 1'b1; @(negedge clk); chk("t4_port1_v", 32'(tx_valid), 1);
    tick(); @(negedge clk); chk("t4_ack", 32'(ack[3]), 1);
    idle(4);

    // Ready toggling, full vector
    tick(); req[1] = 1'b1; pv[1] = 8'hFF; ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(); ready = ~ready;
      @(negedge clk);
      if (tx_valid && ready) got.push_back(int'(tx_port));
    end
    chk("t5_count", 32'(got.size()), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk("t5_order", 32'(got[i]), 32'(i));
    ready = 1'b1;
    idle(4);

    // Reset mid-vector, request re-served in full
    tick(); req[0] = 1'b1; pv[0] = 8'hF0; ready = 1'b0;
    idle(3);
    tick(); rst_n = 1'b0; #2;
    chk("t6_rst_valid", 32'(tx_valid), 0); chk("t6_rst_port", 32'(tx_port), 0);
    chk("t6_rst_type", 32'(tx_type), 0); chk("t6_rst_cnt", 32'(drop_cnt), 0);
    tick();
    tick(); rst_n = 1'b1; ready = 1'b1;
    @(negedge clk); chk("t6_idle_v", 32'(tx_valid), 0);
    for (int p = 4; p < 8; p++) begin
      tick(); @(negedge clk);
      chk("t6_v", 32'(tx_valid), 1); chk("t6_port", 32'(tx_port), 32'(p));
    end
    tick(); @(negedge clk); chk("t6_ack", 32'(ack[0]), 1);
    idle(4);

    // Randomized traffic with varying ready behaviour
    rand_on = 1'b1;
    rmode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) rmode = int'($urandom_range(0, 2));
      tick();
      case (rmode)
        0: ready = ($urandom_range(0, 7) != 0);
        1: ready = 1'($urandom);
        default: ready = ($urandom_range(0, 39) == 0);
      endcase
    end
    rand_on = 1'b0;
    ready = 1'b1;
    idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
